// File: rtl/mc_alu_pkg.sv
// Shared opcode encodings and FSM state type for the multi-cycle ALU.
package mc_alu_pkg;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_AND = 4'd2;
   localparam logic [3:0] OP_OR  = 4'd3;
   localparam logic [3:0] OP_XOR = 4'd4;
   localparam logic [3:0] OP_NOT = 4'd5;
   localparam logic [3:0] OP_SHL = 4'd6;
   localparam logic [3:0] OP_SHR = 4'd7;
   localparam logic [3:0] OP_MUL = 4'd8;
   localparam logic [3:0] OP_DIV = 4'd9;
   localparam logic [3:0] OP_MOD = 4'd10;
   localparam logic [3:0] OP_EQ  = 4'd11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // Opcodes 1100..1111 are unassigned.
   function automatic logic is_illegal_op(input logic [3:0] op);
      return op[3] & op[2];
   endfunction

endpackage

// File: rtl/mc_alu_divider.sv
// Iterative restoring divider: one quotient bit per cycle, WIDTH cycles per divide.
module mc_alu_divider
   import mc_alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] quotient_o,
   output logic [WIDTH-1:0] remainder_o,
   output logic             done_o
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic             busy_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] rem_q;
   logic [WIDTH-1:0] quo_q;
   logic [WIDTH-1:0] dvs_q;

   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   trial;
   logic [WIDTH-1:0] rem_n;
   logic [WIDTH-1:0] quo_n;

   // Outputs carry the result of the step taking place this cycle, so the
   // caller can capture the final quotient/remainder on the same edge.
   always_comb begin
      shifted = {rem_q, quo_q[WIDTH-1]};
      trial   = shifted - {1'b0, dvs_q};
      if (trial[WIDTH]) begin
         rem_n = shifted[WIDTH-1:0];
         quo_n = {quo_q[WIDTH-2:0], 1'b0};
      end else begin
         rem_n = trial[WIDTH-1:0];
         quo_n = {quo_q[WIDTH-2:0], 1'b1};
      end
   end

   assign quotient_o  = quo_n;
   assign remainder_o = rem_n;
   assign done_o      = busy_q && (cnt_q == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= 1'b0;
         cnt_q  <= '0;
         rem_q  <= '0;
         quo_q  <= '0;
         dvs_q  <= '0;
      end else if (start_i) begin
         busy_q <= 1'b1;
         cnt_q  <= '0;
         rem_q  <= '0;
         quo_q  <= a_i;
         dvs_q  <= b_i;
      end else if (busy_q) begin
         rem_q <= rem_n;
         quo_q <= quo_n;
         cnt_q <= cnt_q + 1'b1;
         if (done_o) begin
            busy_q <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/mc_alu.sv
// Multi-cycle ALU: single-cycle logic/arith ops, iterative shift-add multiply,
// restoring divide/modulo, valid/ready on both request and result sides.
module mc_alu
   import mc_alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   A,
   input  logic [WIDTH-1:0]   B,
   input  logic [3:0]         sel,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] result,
   output logic               zero,
   output logic               dbz,
   output logic               illegal,
   output state_t             dbg_state_o
);

   localparam int W2 = 2 * WIDTH;
   localparam int CW = $clog2(WIDTH) + 1;
   localparam int SW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   // Handshake: a request transfers on a rising edge where in_valid && in_ready;
   // a result transfers on a rising edge where out_valid && out_ready. Outputs
   // stay stable while out_valid is high and out_ready is low.

   state_t           state_q, state_d;
   logic [W2-1:0]    result_q, result_d;
   logic             zero_q, zero_d;
   logic             dbz_q, dbz_d;
   logic             illegal_q, illegal_d;
   logic             is_mod_q, is_mod_d;
   logic [W2-1:0]    mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [W2-1:0]    acc_q, acc_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic             accept;
   logic [W2-1:0]    a_ext, b_ext;
   logic [SW-1:0]    shamt;
   logic [W2-1:0]    alu_res;
   logic [W2-1:0]    mul_sum;
   logic             load_res;
   logic [W2-1:0]    res_new;
   logic             div_start;
   logic [WIDTH-1:0] div_quo, div_rem;
   logic             div_done;

   assign in_ready    = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
   assign accept      = in_valid && in_ready;
   assign out_valid   = (state_q == ST_DONE);
   assign result      = result_q;
   assign zero        = zero_q;
   assign dbz         = dbz_q;
   assign illegal     = illegal_q;
   assign dbg_state_o = state_q;

   assign a_ext   = {{WIDTH{1'b0}}, A};
   assign b_ext   = {{WIDTH{1'b0}}, B};
   assign shamt   = SW'(32'(B) % WIDTH);
   assign mul_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

   always_comb begin
      alu_res = '0;
      case (sel)
         OP_ADD:  alu_res = a_ext + b_ext;
         OP_SUB:  alu_res = a_ext - b_ext;
         OP_AND:  alu_res = a_ext & b_ext;
         OP_OR:   alu_res = a_ext | b_ext;
         OP_XOR:  alu_res = a_ext ^ b_ext;
         OP_NOT:  alu_res = {{WIDTH{1'b0}}, ~A};
         OP_SHL:  alu_res = a_ext << shamt;
         OP_SHR:  alu_res = a_ext >> shamt;
         OP_EQ:   alu_res = {{(W2-1){1'b0}}, (A == B)};
         default: alu_res = '0;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      result_d  = result_q;
      zero_d    = zero_q;
      dbz_d     = dbz_q;
      illegal_d = illegal_q;
      is_mod_d  = is_mod_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      div_start = 1'b0;
      load_res  = 1'b0;
      res_new   = '0;

      case (state_q)
         ST_MUL: begin
            acc_d    = mul_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               state_d  = ST_DONE;
               cnt_d    = '0;
               load_res = 1'b1;
               res_new  = mul_sum;
            end
         end
         ST_DIV: begin
            if (div_done) begin
               state_d  = ST_DONE;
               load_res = 1'b1;
               res_new  = is_mod_q ? {{WIDTH{1'b0}}, div_rem} : {{WIDTH{1'b0}}, div_quo};
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: ;
      endcase

      // Accept overrides the DONE->IDLE retire so back-to-back requests see no bubble.
      if (accept) begin
         dbz_d     = 1'b0;
         illegal_d = 1'b0;
         is_mod_d  = (sel == OP_MOD);
         if (is_illegal_op(sel)) begin
            state_d   = ST_DONE;
            illegal_d = 1'b1;
            load_res  = 1'b1;
            res_new   = '0;
         end else if (sel == OP_MUL) begin
            state_d  = ST_MUL;
            mcand_d  = a_ext;
            mplier_d = B;
            acc_d    = '0;
            cnt_d    = '0;
         end else if ((sel == OP_DIV) || (sel == OP_MOD)) begin
            if (B == '0) begin
               state_d  = ST_DONE;
               dbz_d    = 1'b1;
               load_res = 1'b1;
               res_new  = (sel == OP_MOD) ? a_ext : {{WIDTH{1'b0}}, {WIDTH{1'b1}}};
            end else begin
               state_d   = ST_DIV;
               div_start = 1'b1;
            end
         end else begin
            state_d  = ST_DONE;
            load_res = 1'b1;
            res_new  = alu_res;
         end
      end

      if (load_res) begin
         result_d = res_new;
         zero_d   = (res_new == '0);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         result_q  <= '0;
         zero_q    <= 1'b0;
         dbz_q     <= 1'b0;
         illegal_q <= 1'b0;
         is_mod_q  <= 1'b0;
         mcand_q   <= '0;
         mplier_q  <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         result_q  <= result_d;
         zero_q    <= zero_d;
         dbz_q     <= dbz_d;
         illegal_q <= illegal_d;
         is_mod_q  <= is_mod_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
      end
   end

   mc_alu_divider #(
      .WIDTH(WIDTH)
   ) u_divider (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_i     (div_start),
      .a_i         (A),
      .b_i         (B),
      .quotient_o  (div_quo),
      .remainder_o (div_rem),
      .done_o      (div_done)
   );

endmodule

// File: tb/tb_mc_alu.sv
// Bench for mc_alu (WIDTH=8): vector table, directed corner sequences and
// random operations checked against an arithmetic reference model.
module tb_mc_alu;
   import mc_alu_pkg::*;

   localparam int W = 8;

   typedef struct {
      logic [3:0]     sel;
      logic [W-1:0]   a;
      logic [W-1:0]   b;
      logic [2*W-1:0] res;
      logic           z;
      logic           d;
      logic           il;
      int             lat;
   } vec_t;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           in_valid = 1'b0;
   logic           out_ready = 1'b1;
   logic [W-1:0]   a_in = '0;
   logic [W-1:0]   b_in = '0;
   logic [3:0]     sel = '0;
   logic           in_ready;
   logic           out_valid;
   logic [2*W-1:0] result;
   logic           zero;
   logic           dbz;
   logic           illegal;
   state_t         dbg_state;

   int checks = 0;
   int errors = 0;
   logic [2*W-1:0] exp_q[$];
   vec_t tbl[16];

   mc_alu #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .A           (a_in),
      .B           (b_in),
      .sel         (sel),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .result      (result),
      .zero        (zero),
      .dbz         (dbz),
      .illegal     (illegal),
      .dbg_state_o (dbg_state)
   );

   // ---------------- clock / reset
   always #5 clk = ~clk;

   // ---------------- checking helpers
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [3:0] s, input int a, input int b, input int res,
                               input logic z, input logic d, input logic il, input int lat);
      vec_t v;
      v.sel = s; v.a = W'(a); v.b = W'(b); v.res = (2*W)'(res);
      v.z = z; v.d = d; v.il = il; v.lat = lat;
      return v;
   endfunction

   // Reference model: plain arithmetic on integers.
   task automatic model(input logic [3:0] s, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [2*W-1:0] r, output logic d, output logic il, output int lat);
      int ua, ub;
      ua = int'(a); ub = int'(b);
      d = 1'b0; il = 1'b0; lat = 1; r = '0;
      case (s)
         4'd0:  r = (2*W)'(ua + ub);
         4'd1:  r = (2*W)'(ua - ub);
         4'd2:  r = (2*W)'(ua & ub);
         4'd3:  r = (2*W)'(ua | ub);
         4'd4:  r = (2*W)'(ua ^ ub);
         4'd5:  r = (2*W)'(255 - ua);
         4'd6:  r = (2*W)'(ua * (1 << (ub % W)));
         4'd7:  r = (2*W)'(ua / (1 << (ub % W)));
         4'd8:  begin r = (2*W)'(ua * ub); lat = W + 1; end
         4'd9:  if (ub == 0) begin r = 16'd255; d = 1'b1; end
                else begin r = (2*W)'(ua / ub); lat = W + 1; end
         4'd10: if (ub == 0) begin r = (2*W)'(ua); d = 1'b1; end
                else begin r = (2*W)'(ua % ub); lat = W + 1; end
         4'd11: r = (ua == ub) ? 16'd1 : 16'd0;
         default: begin r = '0; il = 1'b1; end
      endcase
   endtask

   // ---------------- driver tasks (called #1 after a rising edge)
   task automatic issue(input logic [3:0] s, input logic [W-1:0] a, input logic [W-1:0] b);
      in_valid = 1'b1; sel = s; a_in = a; b_in = b;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_result(output int lat, output int rdy_hi);
      lat = 1; rdy_hi = 0;
      while (!out_valid && lat < 40) begin
         if (in_ready) rdy_hi++;
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic run_op(input string tag, input logic [3:0] s, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [2*W-1:0] er, input logic ez,
                         input logic ed, input logic eil, input int elat);
      int lat, rdy_hi;
      chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
      issue(s, a, b);
      wait_result(lat, rdy_hi);
      chk({tag, " latency"}, 32'(lat), 32'(elat));
      chk({tag, " in_ready while busy"}, 32'(rdy_hi), 32'd0);
      chk({tag, " result"}, 32'(result), 32'(er));
      chk({tag, " zero"}, 32'(zero), 32'(ez));
      chk({tag, " dbz"}, 32'(dbz), 32'(ed));
      chk({tag, " illegal"}, 32'(illegal), 32'(eil));
      @(posedge clk); #1;
   endtask

   // ---------------- stimulus
   initial begin
      int lat, rdy_hi, seen;
      logic [2*W-1:0] r;
      logic d, il;
      logic [3:0] s;
      logic [W-1:0] a, b;

      tbl[0]  = mk(OP_ADD, 10, 5, 15,    0, 0, 0, 1);
      tbl[1]  = mk(OP_SUB, 10, 5, 5,     0, 0, 0, 1);
      tbl[2]  = mk(OP_AND, 10, 5, 0,     1, 0, 0, 1);
      tbl[3]  = mk(OP_OR,  10, 5, 15,    0, 0, 0, 1);
      tbl[4]  = mk(OP_XOR, 10, 5, 15,    0, 0, 0, 1);
      tbl[5]  = mk(OP_NOT, 10, 5, 245,   0, 0, 0, 1);
      tbl[6]  = mk(OP_SHL, 10, 5, 320,   0, 0, 0, 1);
      tbl[7]  = mk(OP_SHR, 10, 5, 0,     1, 0, 0, 1);
      tbl[8]  = mk(OP_MUL, 10, 5, 50,    0, 0, 0, W + 1);
      tbl[9]  = mk(OP_DIV, 10, 5, 2,     0, 0, 0, W + 1);
      tbl[10] = mk(OP_MOD, 10, 5, 0,     1, 0, 0, W + 1);
      tbl[11] = mk(OP_EQ,  10, 5, 0,     1, 0, 0, 1);
      tbl[12] = mk(OP_MUL, 200, 255, 51000, 0, 0, 0, W + 1);
      tbl[13] = mk(OP_DIV, 10, 0, 255,   0, 1, 0, 1);
      tbl[14] = mk(OP_MOD, 10, 0, 10,    0, 1, 0, 1);
      tbl[15] = mk(4'hC,   3, 4, 0,      1, 0, 1, 1);

      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("reset out_valid", 32'(out_valid), 32'd0);
      chk("reset result", 32'(result), 32'd0);
      chk("reset zero", 32'(zero), 32'd0);
      chk("reset state", 32'(dbg_state), 32'(ST_IDLE));
      rst_n = 1'b1;

      // vector table; first op lands on the first edge after release
      for (int i = 0; i < 16; i++) begin
         run_op($sformatf("vec%0d", i), tbl[i].sel, tbl[i].a, tbl[i].b, tbl[i].res,
                tbl[i].z, tbl[i].d, tbl[i].il, tbl[i].lat);
      end

      // result held under backpressure, new request blocked
      out_ready = 1'b0;
      issue(OP_ADD, 8'd1, 8'd2);
      wait_result(lat, rdy_hi);
      chk("hold latency", 32'(lat), 32'd1);
      in_valid = 1'b1; sel = OP_XOR; a_in = 8'd7; b_in = 8'd7;
      for (int i = 0; i < 5; i++) begin
         chk("hold out_valid", 32'(out_valid), 32'd1);
         chk("hold result", 32'(result), 32'd3);
         chk("hold in_ready", 32'(in_ready), 32'd0);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      #1;
      chk("release in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("after hold result", 32'(result), 32'd0);
      chk("after hold zero", 32'(zero), 32'd1);
      chk("after hold out_valid", 32'(out_valid), 32'd1);
      @(posedge clk); #1;

      // reset in the middle of a multiply
      run_op("pre-reset add", OP_ADD, 8'd1, 8'd2, 16'd3, 1'b0, 1'b0, 1'b0, 1);
      issue(OP_MUL, 8'd200, 8'd255);
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("abort out_valid", 32'(out_valid), 32'd0);
      chk("abort result", 32'(result), 32'd0);
      chk("abort state", 32'(dbg_state), 32'(ST_IDLE));
      repeat (3) @(posedge clk);
      #5;
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      chk("abort no out_valid", 32'(seen), 32'd0);

      // back-to-back, then illegal opcode
      in_valid = 1'b1; sel = OP_ADD; a_in = 8'd3; b_in = 8'd4;
      @(posedge clk); #1;
      chk("b2b add valid", 32'(out_valid), 32'd1);
      chk("b2b add result", 32'(result), 32'd7);
      sel = OP_XOR; a_in = 8'd12; b_in = 8'd10;
      @(posedge clk); #1;
      chk("b2b xor valid", 32'(out_valid), 32'd1);
      chk("b2b xor result", 32'(result), 32'd6);
      sel = 4'hF;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("b2b illegal flag", 32'(illegal), 32'd1);
      chk("b2b illegal result", 32'(result), 32'd0);
      chk("b2b illegal zero", 32'(zero), 32'd1);
      @(posedge clk); #1;
      chk("b2b retire", 32'(out_valid), 32'd0);

      // random operations against the reference model
      for (int i = 0; i < 60; i++) begin
         s = 4'($urandom_range(0, 15));
         a = W'($urandom);
         b = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
         model(s, a, b, r, d, il, lat);
         exp_q.push_back(r);
         run_op($sformatf("rnd%0d op%0d", i, s), s, a, b, exp_q.pop_front(),
                (r == '0), d, il, lat);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mc_alu.md
MC_ALU -- requirements
Module: mc_alu

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits (legal range 4..32).
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  operation request valid.
REQ-005 in_ready  output  1  block can accept a request this cycle.
REQ-006 A  input  WIDTH  operand A, unsigned.
REQ-007 B  input  WIDTH  operand B, unsigned.
REQ-008 sel  input  4  opcode.
REQ-009 out_valid  output  1  result and flags valid.
REQ-010 out_ready  input  1  consumer takes the result this cycle.
REQ-011 result  output  2*WIDTH  operation result.
REQ-012 zero  output  1  high when result == 0.
REQ-013 dbz  output  1  divide-by-zero flag (DIV/MOD with B == 0).
REQ-014 illegal  output  1  opcode 1100..1111 received.

Function
REQ-015 Accept occurs on a rising edge with in_valid && in_ready; A, B and sel are captured only at accept.
REQ-016 FSM states: IDLE, MUL, DIV, DONE; in_ready = (IDLE) || (DONE && out_ready).
REQ-017 Opcodes: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 NOT A, 0110 SHL, 0111 SHR, 1000 MUL, 1001 DIV, 1010 MOD, 1011 EQ.
REQ-018 ADD: zero-extended A+B including carry; SUB: (A-B) modulo 2^(2*WIDTH); AND/OR/XOR/NOT: zero-extended bitwise result.
REQ-019 SHL/SHR: shift amount = B mod WIDTH; zero-extended A shifted in 2*WIDTH bits, zero fill.
REQ-020 EQ: result = 1 if A == B, else 0.
REQ-021 Single-cycle ops (all except MUL, DIV, MOD) go IDLE/DONE -> DONE on accept; out_valid high on the cycle after accept.
REQ-022 MUL: iterative shift-add, exactly WIDTH cycles in MUL state, then DONE; out_valid first high WIDTH+1 cycles after accept; result = A*B exact.
REQ-023 DIV/MOD with B != 0: iterative restoring division, exactly WIDTH cycles in DIV state, then DONE; DIV result = zero-extended quotient, MOD result = zero-extended remainder.
REQ-024 DIV/MOD with B == 0: no iteration, straight to DONE; dbz = 1; DIV result = all ones in low WIDTH bits, upper bits 0; MOD result = zero-extended A.
REQ-025 Opcode 1100..1111: straight to DONE; illegal = 1, result = 0, zero = 1.
REQ-026 result, zero, dbz, illegal are registered and held stable while out_valid && !out_ready.
REQ-027 DONE with out_ready && !in_valid -> IDLE, out_valid low next cycle.
REQ-028 DONE with out_ready && in_valid: new request accepted the same edge (back-to-back, no bubble for single-cycle ops).
REQ-029 in_valid while in MUL/DIV is ignored (in_ready low); no request is queued.
REQ-030 dbz and illegal are cleared on every accept and reflect only the current result.

Reset
REQ-031 rst_n low forces state IDLE, out_valid 0, result 0, zero 0, dbz 0, illegal 0, iteration counter 0, immediately and asynchronously.
REQ-032 Reset asserted during MUL or DIV aborts the operation; no out_valid is produced for it after reset release.
REQ-033 First accept is possible on the first rising edge with rst_n high.

Structure
REQ-034 Package mc_alu_pkg holds opcode localparams (OP_ADD..OP_EQ) and the FSM state encoding.
REQ-035 Iterative restoring divider is sub-module mc_alu_divider (start, A, B in; quotient, remainder, done out), parametrised by WIDTH.
REQ-036 Multiplier, shifter and single-cycle ops stay in mc_alu; the iteration counter is $clog2(WIDTH)+1 bits.

Verification (WIDTH=8)
REQ-037 A=10, B=5, each of ADD..EQ, out_ready=1 -> 15, 5, 0, 15, 15, 245, 320, 0, 50, 2, 0, 0; zero only for AND/SHR/MOD/EQ.
REQ-038 MUL A=200, B=255 -> out_valid exactly 9 cycles after accept, result=51000, in_ready low for those cycles.
REQ-039 DIV A=10, B=0 -> out_valid next cycle, result=255, dbz=1; MOD A=10, B=0 -> result=10, dbz=1.
REQ-040 ADD A=1, B=2 with out_ready=0 for 5 cycles -> result=3 and out_valid held; in_valid with new op not accepted until out_ready=1.
REQ-041 rst_n pulsed low 3 cycles into a MUL -> outputs 0 immediately, state IDLE, no out_valid after release.
REQ-042 Back-to-back ADD, XOR with in_valid and out_ready held high -> results on consecutive cycles, sel=1111 next -> illegal=1, result=0.
